// File: rtl/match_pkg.sv
// -----------------------------------------------------------------------------
// match_pkg
// Shared definitions for the match controller: FSM state encodings, winner
// encodings, score and timer widths, and a saturating score increment.
// No ports (package).
// -----------------------------------------------------------------------------
package match_pkg;

  localparam int SCORE_W = 4;
  localparam int TIMER_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_t;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  // Scores stop at the top of their range instead of wrapping to zero.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/match_ctrl_frame_timer.sv
// -----------------------------------------------------------------------------
// frame_timer
// 8-bit frame down-counter used for the serve hold and the post-goal pause.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset (count -> 0)
//   ftick      - frame enable; the counter only moves on ftick cycles
//   load       - on an ftick, load load_val instead of counting
//   load_val   - value loaded when load is set
//   expire     - high while the count is 1, i.e. the current frame is the
//                last one of the interval
// -----------------------------------------------------------------------------
module frame_timer
  import match_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               ftick,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               expire
);

  logic [TIMER_W-1:0] count;

  // The count parks at zero once an interval has run out, so an idle timer
  // never raises expire again until it is reloaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (ftick) begin
      if (load) begin
        count <= load_val;
      end else if (count != '0) begin
        count <= count - TIMER_W'(1);
      end
    end
  end

  assign expire = (count == TIMER_W'(1));

endmodule

// File: rtl/match_ctrl.sv
// -----------------------------------------------------------------------------
// match_ctrl
// Match sequencing for a two-player ball game: idle, serve hold, rally,
// post-goal pause and game over, with score keeping and winner detection.
// Optional macro MATCH_CTRL_DEUCE_EN: a win needs a 2-point lead, and a tie
// at WIN_SCORE or above is pulled back to WIN_SCORE-1 each.
// Parameters: WIN_SCORE (1..14), SERVE_FRAMES (1..255), POINT_FRAMES (1..255)
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   ftick             - one-clk frame enable; all progress happens on it
//   start             - level request to begin / restart a match
//   goal_p1, goal_p2  - goal flags; goal_p1 scores for player 1
//   game_rst          - holds ball and paddles at home (low only in PLAY)
//   ball_en           - ball movement enable (high only in PLAY)
//   score_p1/score_p2 - current scores
//   winner            - 00 none, 01 player 1, 10 player 2
//   serve_dir         - 0 serve toward player 1, 1 toward player 2
//   state             - current FSM state for debug LEDs
// -----------------------------------------------------------------------------
module match_ctrl
  import match_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ftick,
  input  logic               start,
  input  logic               goal_p1,
  input  logic               goal_p2,
  output logic               game_rst,
  output logic               ball_en,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic [1:0]         winner,
  output logic               serve_dir,
  output logic [2:0]         state
);

  localparam logic [SCORE_W-1:0] WIN_S   = SCORE_W'(WIN_SCORE);
  localparam logic [TIMER_W-1:0] SERVE_T = TIMER_W'(SERVE_FRAMES);
  localparam logic [TIMER_W-1:0] POINT_T = TIMER_W'(POINT_FRAMES);

  state_t             state_q;
  winner_t            winner_q;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_val;
  logic               timer_expire;
  logic               p1_wins;
  logic               p2_wins;
  logic               match_won;

`ifdef MATCH_CTRL_DEUCE_EN
  localparam logic [SCORE_W-1:0] DEUCE_S = SCORE_W'(WIN_SCORE - 1);
  logic p1_goal_ties;
  logic p2_goal_ties;

  // Extended by one bit so the +2 lead test cannot overflow near the top.
  assign p1_wins = (score_p1 >= WIN_S) &&
                   ({1'b0, score_p1} >= ({1'b0, score_p2} + (SCORE_W+1)'(2)));
  assign p2_wins = (score_p2 >= WIN_S) &&
                   ({1'b0, score_p2} >= ({1'b0, score_p1} + (SCORE_W+1)'(2)));

  // A goal that would produce a tie at or above WIN_SCORE triggers deuce.
  assign p1_goal_ties = (sat_inc(score_p1) == score_p2) && (score_p2 >= WIN_S);
  assign p2_goal_ties = (sat_inc(score_p2) == score_p1) && (score_p1 >= WIN_S);
`else
  assign p1_wins = (score_p1 == WIN_S);
  assign p2_wins = (score_p2 == WIN_S);
`endif

  assign match_won = p1_wins || p2_wins;

  // Timer reload points: match start/restart and end of a pause that does not
  // end the match load the serve hold; any goal (including a replay) loads
  // the post-goal pause. The timer itself only acts on ftick.
  always_comb begin
    timer_load = 1'b0;
    timer_val  = SERVE_T;
    unique case (state_q)
      ST_IDLE, ST_OVER: timer_load = start;
      ST_PLAY: begin
        if (goal_p1 || goal_p2) begin
          timer_load = 1'b1;
          timer_val  = POINT_T;
        end
      end
      ST_POINT: timer_load = timer_expire && !match_won;
      default: ;
    endcase
  end

  frame_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .ftick    (ftick),
    .load     (timer_load),
    .load_val (timer_val),
    .expire   (timer_expire)
  );

  // game_rst and ball_en are updated together with the state so they are
  // registered and always agree with it; PLAY is only entered from SERVE and
  // only left toward POINT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      score_p1  <= '0;
      score_p2  <= '0;
      winner_q  <= WIN_NONE;
      serve_dir <= 1'b0;
      game_rst  <= 1'b1;
      ball_en   <= 1'b0;
    end else if (ftick) begin
      unique case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            score_p1 <= '0;
            score_p2 <= '0;
            winner_q <= WIN_NONE;
            state_q  <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (timer_expire) begin
            state_q  <= ST_PLAY;
            game_rst <= 1'b0;
            ball_en  <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (goal_p1 || goal_p2) begin
            state_q  <= ST_POINT;
            game_rst <= 1'b1;
            ball_en  <= 1'b0;
            // Simultaneous goals are a replay: no score, serve side kept.
            if (goal_p1 && !goal_p2) begin
              serve_dir <= 1'b1;
`ifdef MATCH_CTRL_DEUCE_EN
              if (p1_goal_ties) begin
                score_p1 <= DEUCE_S;
                score_p2 <= DEUCE_S;
              end else begin
                score_p1 <= sat_inc(score_p1);
              end
`else
              score_p1 <= sat_inc(score_p1);
`endif
            end else if (goal_p2 && !goal_p1) begin
              serve_dir <= 1'b0;
`ifdef MATCH_CTRL_DEUCE_EN
              if (p2_goal_ties) begin
                score_p1 <= DEUCE_S;
                score_p2 <= DEUCE_S;
              end else begin
                score_p2 <= sat_inc(score_p2);
              end
`else
              score_p2 <= sat_inc(score_p2);
`endif
            end
          end
        end
        ST_POINT: begin
          if (timer_expire) begin
            if (match_won) begin
              state_q  <= ST_OVER;
              winner_q <= p1_wins ? WIN_P1 : WIN_P2;
            end else begin
              state_q <= ST_SERVE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign winner = winner_q;
  assign state  = state_q;

endmodule

// File: tb/tb_match_ctrl.sv
// -----------------------------------------------------------------------------
// tb_match_ctrl
// Self-checking bench for match_ctrl (WIN_SCORE=3, SERVE_FRAMES=3,
// POINT_FRAMES=2). A behavioural match model tracks phase, frames remaining
// and scores; every cycle all outputs are compared against it, with extra
// directed checks at the interesting points and a randomized run at the end.
// Honours MATCH_CTRL_DEUCE_EN in the model and adds a deuce scenario.
// -----------------------------------------------------------------------------
module tb_match_ctrl;

  localparam int WIN = 3;
  localparam int SF  = 3;
  localparam int PF  = 2;

  localparam int S_IDLE  = 0;
  localparam int S_SERVE = 1;
  localparam int S_PLAY  = 2;
  localparam int S_POINT = 3;
  localparam int S_OVER  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ftick = 1'b0;
  logic       start = 1'b0;
  logic       goal_p1 = 1'b0;
  logic       goal_p2 = 1'b0;
  logic       game_rst;
  logic       ball_en;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic [1:0] winner;
  logic       serve_dir;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  int m_state = S_IDLE;
  int m_s1    = 0;
  int m_s2    = 0;
  int m_win   = 0;
  int m_dir   = 0;
  int m_left  = 0;

  match_ctrl #(
    .WIN_SCORE    (WIN),
    .SERVE_FRAMES (SF),
    .POINT_FRAMES (PF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ftick     (ftick),
    .start     (start),
    .goal_p1   (goal_p1),
    .goal_p2   (goal_p2),
    .game_rst  (game_rst),
    .ball_en   (ball_en),
    .score_p1  (score_p1),
    .score_p2  (score_p2),
    .winner    (winner),
    .serve_dir (serve_dir),
    .state     (state)
  );

  always #10 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit hasWon(input int a, input int b);
`ifdef MATCH_CTRL_DEUCE_EN
    return (a >= WIN) && (a - b >= 2);
`else
    return a == WIN;
`endif
  endfunction

  function automatic int bump(input int s);
    return (s < 15) ? s + 1 : 15;
  endfunction

  // Match rules at phase level: frames remaining in the current phase count
  // down and the phase changes when none are left.
  task automatic modelStep();
    if (rst) begin
      m_state = S_IDLE; m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 0; m_left = 0;
    end else if (ftick) begin
      case (m_state)
        S_IDLE, S_OVER: begin
          if (start) begin
            m_s1 = 0; m_s2 = 0; m_win = 0; m_left = SF; m_state = S_SERVE;
          end
        end
        S_SERVE: begin
          m_left--;
          if (m_left == 0) m_state = S_PLAY;
        end
        S_PLAY: begin
          if (goal_p1 || goal_p2) begin
            if (goal_p1 && !goal_p2) begin
              m_s1 = bump(m_s1); m_dir = 1;
            end else if (goal_p2 && !goal_p1) begin
              m_s2 = bump(m_s2); m_dir = 0;
            end
`ifdef MATCH_CTRL_DEUCE_EN
            if (m_s1 == m_s2 && m_s1 >= WIN) begin
              m_s1 = WIN - 1; m_s2 = WIN - 1;
            end
`endif
            m_left = PF; m_state = S_POINT;
          end
        end
        S_POINT: begin
          m_left--;
          if (m_left == 0) begin
            if (hasWon(m_s1, m_s2)) begin
              m_win = 1; m_state = S_OVER;
            end else if (hasWon(m_s2, m_s1)) begin
              m_win = 2; m_state = S_OVER;
            end else begin
              m_left = SF; m_state = S_SERVE;
            end
          end
        end
        default: m_state = S_IDLE;
      endcase
    end
  endtask

  task automatic compareModel();
    checkOutput("state", state, m_state);
    checkOutput("score_p1", score_p1, m_s1);
    checkOutput("score_p2", score_p2, m_s2);
    checkOutput("winner", winner, m_win);
    checkOutput("serve_dir", serve_dir, m_dir);
    checkOutput("ball_en", ball_en, (m_state == S_PLAY) ? 1 : 0);
    checkOutput("game_rst", game_rst, (m_state == S_PLAY) ? 0 : 1);
  endtask

  // Inputs change on the falling edge; outputs are read 1 unit after the
  // rising edge once the model has taken the same step.
  task automatic applyStimulus(input bit r, input bit f, input bit s,
                               input bit g1, input bit g2);
    @(negedge clk);
    rst = r; ftick = f; start = s; goal_p1 = g1; goal_p2 = g2;
    @(posedge clk);
    modelStep();
    #1;
    compareModel();
  endtask

  task automatic tick(input bit s, input bit g1, input bit g2);
    applyStimulus(1'b0, 1'b1, s, g1, g2);
  endtask

  // Non-frame cycle with noisy inputs that must all be ignored.
  task automatic gap();
    applyStimulus(1'b0, 1'b0, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
  endtask

  task automatic serveIn();
    for (int i = 0; i < SF; i++) begin
      gap();
      tick(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic pointOut();
    for (int i = 0; i < PF; i++) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic playPoint(input bit g1, input bit g2);
    serveIn();
    tick(1'b0, g1, g2);
    pointOut();
  endtask

  initial begin
    // Reset, including one cycle with every input active.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("rst_state", state, S_IDLE);
    checkOutput("rst_score", {score_p1, score_p2}, 0);
    checkOutput("rst_game_rst", game_rst, 1);
    checkOutput("rst_ball_en", ball_en, 0);

    // Start only counts on a frame tick.
    tick(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("start_no_tick", state, S_IDLE);
    tick(1'b1, 1'b0, 1'b0);
    checkOutput("start_serve", state, S_SERVE);

    // Serve length: PLAY exactly after the third tick.
    tick(1'b0, 1'b0, 1'b0);
    gap();
    tick(1'b0, 1'b0, 1'b0);
    checkOutput("serve_2nd", state, S_SERVE);
    tick(1'b0, 1'b0, 1'b0);
    checkOutput("serve_3rd", state, S_PLAY);
    checkOutput("serve_ball_en", ball_en, 1);
    checkOutput("serve_game_rst", game_rst, 0);

    // Player-1 goal.
    tick(1'b0, 1'b1, 1'b0);
    checkOutput("p1goal_score", score_p1, 1);
    checkOutput("p1goal_dir", serve_dir, 1);
    checkOutput("p1goal_state", state, S_POINT);
    pointOut();
    checkOutput("p1goal_serve", state, S_SERVE);

    // Start held through a serve is ignored.
    for (int i = 0; i < SF; i++) tick(1'b1, 1'b0, 1'b0);
    checkOutput("start_ignored", state, S_PLAY);

    // Simultaneous goals replay.
    tick(1'b0, 1'b1, 1'b1);
    checkOutput("both_s1", score_p1, 1);
    checkOutput("both_s2", score_p2, 0);
    checkOutput("both_dir", serve_dir, 1);
    checkOutput("both_state", state, S_POINT);
    pointOut();

    // Player 2 takes three goals and the match.
    for (int i = 0; i < 3; i++) playPoint(1'b0, 1'b1);
    checkOutput("win_state", state, S_OVER);
    checkOutput("win_winner", winner, 2);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    checkOutput("over_frozen", {score_p1, score_p2}, {4'd1, 4'd3});
    tick(1'b1, 1'b0, 1'b0);
    checkOutput("restart_state", state, S_SERVE);
    checkOutput("restart_score", {score_p1, score_p2}, 0);
    checkOutput("restart_winner", winner, 0);

    // Reset in the middle of a rally at 2-1.
    playPoint(1'b1, 1'b0);
    playPoint(1'b1, 1'b0);
    playPoint(1'b0, 1'b1);
    serveIn();
    checkOutput("mid_state", state, S_PLAY);
    checkOutput("mid_score", {score_p1, score_p2}, {4'd2, 4'd1});
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mid_rst_state", state, S_IDLE);
    checkOutput("mid_rst_score", {score_p1, score_p2}, 0);
    checkOutput("mid_rst_game_rst", game_rst, 1);
    checkOutput("mid_rst_ball_en", ball_en, 0);

`ifdef MATCH_CTRL_DEUCE_EN
    // Deuce: 3-3 collapses to 2-2, then two clear goals win it.
    tick(1'b1, 1'b0, 1'b0);
    playPoint(1'b1, 1'b0);
    playPoint(1'b1, 1'b0);
    playPoint(1'b0, 1'b1);
    playPoint(1'b0, 1'b1);
    playPoint(1'b1, 1'b0);
    checkOutput("deuce_3_2_state", state, S_SERVE);
    serveIn();
    tick(1'b0, 1'b0, 1'b1);
    checkOutput("deuce_reset", {score_p1, score_p2}, {4'd2, 4'd2});
    pointOut();
    playPoint(1'b1, 1'b0);
    playPoint(1'b1, 1'b0);
    checkOutput("deuce_state", state, S_OVER);
    checkOutput("deuce_winner", winner, 1);
`endif

    // Randomized run against the model.
    for (int i = 0; i < 4000; i++) begin
      applyStimulus(1'(($urandom % 400) == 0), 1'(($urandom % 3) != 0),
                    1'(($urandom % 10) == 0), 1'(($urandom % 4) == 0),
                    1'(($urandom % 4) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
